task_dispatcher: RTL and testbench

TASK_DISPATCHER -- requirements
Module: task_dispatcher

---
 rtl/task_dispatcher_if.sv | 26 ++
 rtl/task_dispatcher.sv | 120 ++++++++++++
 tb/tb_task_dispatcher.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/task_dispatcher_if.sv
// task_dispatcher_if: processor-facing control and status bus of the task dispatcher
interface task_dispatcher_if #(
  parameter int PROC_CNT = 4,
  parameter int ADDR_W = 8,
  parameter int Q_DEPTH = 16
);
  logic start;
  logic [PROC_CNT-1:0] proc_running;
  logic [PROC_CNT-1:0] proc_onspawn;
  logic [PROC_CNT*ADDR_W-1:0] proc_spawn_addr;
  logic [PROC_CNT-1:0] proc_ack;
  logic [PROC_CNT-1:0] proc_start;
  logic [PROC_CNT*ADDR_W-1:0] proc_start_addr;
  logic busy;
  logic done;
  logic [$clog2(Q_DEPTH):0] q_level;
  logic spawn_stall;
  modport master(
    output start, proc_running, proc_onspawn, proc_spawn_addr,
    input proc_ack, proc_start, proc_start_addr, busy, done, q_level, spawn_stall
  );
  modport slave(
    input start, proc_running, proc_onspawn, proc_spawn_addr,
    output proc_ack, proc_start, proc_start_addr, busy, done, q_level, spawn_stall
  );
endinterface

// File: rtl/task_dispatcher.sv
// task_dispatcher: round-robin scan that queues spawned tasks and dispatches them to idle processors
module task_dispatcher #(
  parameter int PROC_CNT = 4,
  parameter int ADDR_W = 8,
  parameter int Q_DEPTH = 16,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input logic clock,
  input logic reset,
  task_dispatcher_if.slave bus
);
  localparam int PW = $clog2(PROC_CNT);
  localparam int QW = $clog2(Q_DEPTH);
  localparam int CW = $clog2(PROC_CNT + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [QW:0] lvl_q, lvl_d;
  logic [ADDR_W-1:0] mem_q [Q_DEPTH];
  logic [ADDR_W-1:0] mem_d [Q_DEPTH];
  logic [PROC_CNT-1:0] ack_q, ack_d, last_q, last_d, launched_q, launched_d, start_q, start_d;
  logic [PROC_CNT*ADDR_W-1:0] addr_q, addr_d;
  logic done_q, done_d;
  logic pend, idle, full, stall;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    rd_d = rd_q;
    lvl_d = lvl_q;
    mem_d = mem_q;
    ack_d = ack_q;
    last_d = last_q;
    launched_d = launched_q & ~bus.proc_running;
    start_d = '0;
    addr_d = addr_q;
    done_d = done_q;
    pend = bus.proc_onspawn[ptr_q] ^ last_q[ptr_q];
    idle = !bus.proc_running[ptr_q] && !launched_q[ptr_q];
    full = lvl_q == (QW+1)'(Q_DEPTH);
    stall = 1'b0;
    if (state_q != SCAN && bus.start) begin
      state_d = SCAN;
      ptr_d = '0;
      cnt_d = '0;
      wr_d = '0;
      rd_d = '0;
      lvl_d = '0;
      done_d = 1'b0;
      start_d[0] = 1'b1;
      addr_d[ADDR_W-1:0] = BOOT_ADDR;
      launched_d[0] = 1'b1;
    end else if (state_q == SCAN) begin
      ptr_d = (ptr_q == PW'(PROC_CNT - 1)) ? '0 : ptr_q + 1'b1;
      // window of consecutive quiet visits; any activity restarts it
      cnt_d = (!pend && idle && lvl_q == '0) ? cnt_q + 1'b1 : '0;
      if (pend && !full) begin
        mem_d[wr_q] = bus.proc_spawn_addr[ptr_q*ADDR_W +: ADDR_W];
        wr_d = wr_q + 1'b1;
        lvl_d = lvl_q + 1'b1;
        ack_d[ptr_q] = ~ack_q[ptr_q];
        last_d[ptr_q] = bus.proc_onspawn[ptr_q];
      end else if (pend) begin
        stall = 1'b1;
      end else if (idle && lvl_q != '0) begin
        start_d[ptr_q] = 1'b1;
        addr_d[ptr_q*ADDR_W +: ADDR_W] = mem_q[rd_q];
        launched_d[ptr_q] = 1'b1;
        rd_d = rd_q + 1'b1;
        lvl_d = lvl_q - 1'b1;
      end
      if (cnt_d == CW'(PROC_CNT)) begin
        state_d = DONE;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      ack_q <= bus.proc_onspawn;
      last_q <= bus.proc_onspawn;
      launched_q <= '0;
      start_q <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      ack_q <= ack_d;
      last_q <= last_d;
      launched_q <= launched_d;
      start_q <= start_d;
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end
  assign bus.proc_ack = ack_q;
  assign bus.proc_start = start_q;
  assign bus.proc_start_addr = addr_q;
  assign bus.busy = state_q == SCAN;
  assign bus.done = done_q;
  assign bus.q_level = lvl_q;
  assign bus.spawn_stall = stall;
endmodule

// File: tb/tb_task_dispatcher.sv
// tb_task_dispatcher: directed vector table plus hand-written corner sequences for task_dispatcher
module tb_task_dispatcher;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  task_dispatcher_if #(.PROC_CNT(4), .ADDR_W(8), .Q_DEPTH(16)) ia();
  task_dispatcher_if #(.PROC_CNT(4), .ADDR_W(8), .Q_DEPTH(2)) ib();
  task_dispatcher #(.PROC_CNT(4), .ADDR_W(8), .Q_DEPTH(16), .BOOT_ADDR(8'h5A)) dut_a(
    .clock(clock), .reset(reset), .bus(ia)
  );
  task_dispatcher #(.PROC_CNT(4), .ADDR_W(8), .Q_DEPTH(2), .BOOT_ADDR(8'h00)) dut_b(
    .clock(clock), .reset(reset), .bus(ib)
  );
  typedef struct {
    logic start;
    logic [3:0] run;
    logic [3:0] onsp;
    logic [31:0] saddr;
    logic [3:0] ps;
    logic busy;
    logic done;
    logic [4:0] q;
    logic [3:0] ack;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    tbl[0] = '{1'b1, 4'b0000, 4'b0010, 32'h0, 4'b0001, 1'b1, 1'b0, 5'd0, 4'b0010, 32'h0000005A};
    tbl[1] = '{1'b0, 4'b0001, 4'b0010, 32'h0, 4'b0000, 1'b1, 1'b0, 5'd0, 4'b0010, 32'h0000005A};
    tbl[2] = '{1'b1, 4'b0001, 4'b0010, 32'h0, 4'b0000, 1'b1, 1'b0, 5'd0, 4'b0010, 32'h0000005A};
    tbl[3] = '{1'b0, 4'b0000, 4'b0010, 32'h0, 4'b0000, 1'b1, 1'b0, 5'd0, 4'b0010, 32'h0000005A};
    tbl[4] = '{1'b0, 4'b0000, 4'b0010, 32'h0, 4'b0000, 1'b1, 1'b0, 5'd0, 4'b0010, 32'h0000005A};
    tbl[5] = '{1'b0, 4'b0000, 4'b0010, 32'h0, 4'b0000, 1'b0, 1'b1, 5'd0, 4'b0010, 32'h0000005A};
    tbl[6] = '{1'b1, 4'b0000, 4'b0010, 32'h0, 4'b0001, 1'b1, 1'b0, 5'd0, 4'b0010, 32'h0000005A};
    tbl[7] = '{1'b0, 4'b0000, 4'b0000, 32'h00002A00, 4'b0000, 1'b1, 1'b0, 5'd0, 4'b0010, 32'h0000005A};
    tbl[8] = '{1'b0, 4'b0000, 4'b0000, 32'h00002A00, 4'b0000, 1'b1, 1'b0, 5'd1, 4'b0000, 32'h0000005A};
    tbl[9] = '{1'b0, 4'b0000, 4'b0000, 32'h00002A00, 4'b0100, 1'b1, 1'b0, 5'd0, 4'b0000, 32'h002A005A};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 32'h00002A00, 4'b0000, 1'b1, 1'b0, 5'd0, 4'b0000, 32'h002A005A};
    tbl[11] = '{1'b0, 4'b0101, 4'b0000, 32'h00002A00, 4'b0000, 1'b1, 1'b0, 5'd0, 4'b0000, 32'h002A005A};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 32'h00002A00, 4'b0000, 1'b1, 1'b0, 5'd0, 4'b0000, 32'h002A005A};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000, 32'h00002A00, 4'b0000, 1'b1, 1'b0, 5'd0, 4'b0000, 32'h002A005A};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 32'h00002A00, 4'b0000, 1'b1, 1'b0, 5'd0, 4'b0000, 32'h002A005A};
    tbl[15] = '{1'b0, 4'b0000, 4'b0000, 32'h00002A00, 4'b0000, 1'b0, 1'b1, 5'd0, 4'b0000, 32'h002A005A};
    ia.start = 1'b0;
    ia.proc_running = 4'b0000;
    ia.proc_onspawn = 4'b0010;
    ia.proc_spawn_addr = '0;
    ib.start = 1'b0;
    ib.proc_running = 4'b1111;
    ib.proc_onspawn = 4'b0000;
    ib.proc_spawn_addr = '0;
    tick();
    ia.start = 1'b1;
    tick();
    chk("reset busy", ia.busy, 0);
    chk("reset done", ia.done, 0);
    chk("reset proc_start", ia.proc_start, 0);
    chk("reset q_level", ia.q_level, 0);
    chk("reset ack", ia.proc_ack, 4'b0010);
    chk("reset stall", ia.spawn_stall, 0);
    chk("reset start_addr", ia.proc_start_addr, 0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ia.start = tbl[i].start;
      ia.proc_running = tbl[i].run;
      ia.proc_onspawn = tbl[i].onsp;
      ia.proc_spawn_addr = tbl[i].saddr;
      tick();
      chk($sformatf("r%0d proc_start", i), ia.proc_start, tbl[i].ps);
      chk($sformatf("r%0d busy", i), ia.busy, tbl[i].busy);
      chk($sformatf("r%0d done", i), ia.done, tbl[i].done);
      chk($sformatf("r%0d q_level", i), ia.q_level, tbl[i].q);
      chk($sformatf("r%0d ack", i), ia.proc_ack, tbl[i].ack);
      chk($sformatf("r%0d start_addr", i), ia.proc_start_addr, tbl[i].addr);
    end
    // same-index spawn and idle: push wins, proc 2 served on its next visit
    ia.start = 1'b1;
    ia.proc_running = 4'b1010;
    ia.proc_onspawn = 4'b0110;
    ia.proc_spawn_addr = 32'h00221100;
    tick();
    chk("prio boot", ia.proc_start, 4'b0001);
    ia.start = 1'b0;
    tick();
    tick();
    chk("prio q1", ia.q_level, 1);
    chk("prio ack1", ia.proc_ack, 4'b0010);
    tick();
    chk("prio no start", ia.proc_start, 0);
    chk("prio q2", ia.q_level, 2);
    chk("prio ack2", ia.proc_ack, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("prio idle %0d", i), ia.proc_start, 0);
    end
    tick();
    chk("prio revisit start", ia.proc_start, 4'b0100);
    chk("prio revisit addr", ia.proc_start_addr, 32'h0011005A);
    chk("prio revisit q", ia.q_level, 1);
    // fill to three entries, then reset mid-scan
    ia.proc_onspawn = 4'b1100;
    ia.proc_spawn_addr = 32'h55224400;
    tick();
    tick();
    tick();
    chk("mid q3", ia.q_level, 3);
    chk("mid busy", ia.busy, 1);
    chk("mid ack", ia.proc_ack, 4'b1100);
    reset = 1'b1;
    ia.start = 1'b1;
    tick();
    chk("abort q", ia.q_level, 0);
    chk("abort busy", ia.busy, 0);
    chk("abort start", ia.proc_start, 0);
    chk("abort ack", ia.proc_ack, 4'b1100);
    chk("abort addr", ia.proc_start_addr, 0);
    reset = 1'b0;
    ia.start = 1'b0;
    tick();
    chk("post-reset start", ia.proc_start, 0);
    chk("post-reset busy", ia.busy, 0);
    ia.start = 1'b1;
    tick();
    chk("reboot start", ia.proc_start, 4'b0001);
    chk("reboot addr", ia.proc_start_addr, 32'h0000005A);
    chk("reboot busy", ia.busy, 1);
    ia.start = 1'b0;
    // depth-2 queue with every processor busy: third spawn stalls until space frees
    ib.start = 1'b1;
    tick();
    chk("b boot", ib.proc_start, 4'b0001);
    ib.start = 1'b0;
    ib.proc_onspawn = 4'b1110;
    ib.proc_spawn_addr = 32'hA3A2A100;
    tick();
    tick();
    chk("b q1", ib.q_level, 1);
    chk("b ack1", ib.proc_ack, 4'b0010);
    chk("b no stall", ib.spawn_stall, 0);
    tick();
    chk("b q2", ib.q_level, 2);
    chk("b ack2", ib.proc_ack, 4'b0110);
    chk("b stall", ib.spawn_stall, 1);
    tick();
    chk("b held ack", ib.proc_ack, 4'b0110);
    chk("b held q", ib.q_level, 2);
    tick();
    tick();
    tick();
    chk("b stall again", ib.spawn_stall, 1);
    tick();
    ib.proc_running = 4'b1101;
    tick();
    tick();
    chk("b free start", ib.proc_start, 4'b0010);
    chk("b free addr", ib.proc_start_addr, 32'h0000A100);
    chk("b free q", ib.q_level, 1);
    chk("b free stall", ib.spawn_stall, 0);
    tick();
    tick();
    chk("b ack3", ib.proc_ack, 4'b1110);
    chk("b q refill", ib.q_level, 2);
    ib.proc_running = 4'b1001;
    tick();
    tick();
    tick();
    chk("b A2 start", ib.proc_start, 4'b0100);
    chk("b A2 addr", ib.proc_start_addr, 32'h00A2A100);
    ib.proc_running = 4'b0101;
    tick();
    chk("b A3 start", ib.proc_start, 4'b1000);
    chk("b A3 addr", ib.proc_start_addr, 32'hA3A2A100);
    chk("b drained", ib.q_level, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
